lpmul_seq: RTL
==============

LPMUL_SEQ -- requirements
Module: lpmul_seq

Interface
REQ-001 SHALL have parameter NLANES, default 4, meaning the number of 8-bit lanes per packed operand word (legal range 1..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: request carries valid operands.
REQ-005 SHALL have port in_ready, output, 1 bit: sequencer accepts a request this cycle.
REQ-006 SHALL have port opA, input, NLANES*8 bits: packed lanes, lane i = bits [8i+7:8i].
REQ-007 SHALL have port opB, input, NLANES*8 bits: packed lanes, same layout as opA.
REQ-008 SHALL have port sign, input, 1 bit: signed multiply mode.
REQ-009 SHALL have port sat, input, 1 bit: saturating multiply mode.
REQ-010 SHALL have port out_valid, output, 1 bit: out_res holds a complete result.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 SHALL have port out_res, output, NLANES*16 bits: lane i result = bits [16i+15:16i].
REQ-013 SHALL have port busy, output, 1 bit: high whenever state != IDLE.

Function
REQ-014 SHALL time-multiplex exactly one lpmul instance across all lanes, one lane per cycle; no other multiplier logic.
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 SHALL, in IDLE, drive in_ready=1, out_valid=0, busy=0.
REQ-017 SHALL, in IDLE when in_valid=1, on the clock edge capture opA, opB, sign and sat into internal registers, clear lane counter to 0, and go to RUN.
REQ-018 SHALL, in RUN, drive in_ready=0 and present captured lane[cnt] of A and B, with captured sign and sat, to lpmul.
REQ-019 SHALL, in RUN, write lpmul mul_res into result slot cnt at the clock edge and increment cnt.
REQ-020 SHALL leave RUN for DONE on the edge that writes lane NLANES-1; cnt SHALL NOT wrap past NLANES-1.
REQ-021 SHALL, in DONE, drive out_valid=1 and in_ready=0, and hold out_res stable until the handshake completes.
REQ-022 SHALL, in DONE when out_ready=1, return to IDLE on that edge; the output handshake is valid AND ready.
REQ-023 SHALL assert out_valid exactly NLANES cycles after the accepting edge, with no stalls inside RUN.
REQ-024 SHALL ignore input-port changes after capture; sign and sat SHALL apply uniformly to all lanes of one request.
REQ-025 SHALL NOT accept a new request in DONE, even when out_ready=1 in that cycle; the earliest next accept is the following cycle in IDLE.
REQ-026 SHALL keep out_res at its last value while in IDLE; it is meaningful only while out_valid=1.
REQ-027 SHALL return exactly the combinational lpmul per-lane semantics:
- unsigned: 16-bit product
- signed: two's-complement 16-bit product
- unsigned saturating: 0x00FF on overflow
- signed saturating: 0x007F on positive overflow, 0xFF80 on negative overflow

Reset
REQ-028 SHALL, when rst=1 at a clock edge, force state=IDLE, cnt=0, all result slots and captured operands to 0, out_valid=0, busy=0, in_ready=1 on the following cycle.
REQ-029 SHALL give reset priority over every other event, including an in-flight RUN or a pending DONE handshake; the interrupted request is discarded with no output.
REQ-030 SHALL ignore in_valid in any cycle where rst=1.

Verification
REQ-031 SHALL cover the unsigned case: NLANES=4, sign=0, sat=0, opA=0x14_03_02_01, opB=0x14_05_02_FF -> out_res=0x0190_000F_0004_00FF, with out_valid rising 4 cycles after accept.
REQ-032 SHALL cover the signed case: sign=1, sat=0, lane0 A=0xFE (-2), B=0x03 -> lane0 result 0xFFFA; lane1 A=0x80, B=0x80 -> 0x4000.
REQ-033 SHALL cover saturation:
- sign=1, sat=1: lane0 100*100 -> 0x007F; lane1 -100*100 -> 0xFF80; lane2 -2*3 -> 0xFFFA
- sign=0, sat=1: lane3 20*20 -> 0x00FF
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_res unchanged, in_ready stays 0, and in_valid pulses are ignored; then out_ready=1 -> IDLE on the next edge.
REQ-035 SHALL cover reset mid-operation: rst=1 while cnt=2 in RUN -> next cycle IDLE with out_res=0 and out_valid=0; a new request then completes correctly.
REQ-036 SHALL cover back-to-back traffic: in_valid and out_ready held high -> accepts are spaced NLANES+2 cycles apart and each result matches its own request.

Source files
------------

// File: rtl/lpmul_seq.sv
// Sequential packed-lane multiplier: one shared 8x8 lane multiplier (lpmul) is
// stepped across NLANES lanes, one lane per cycle, behind a valid/ready handshake.

module lpmul (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        sign,
    input  logic        sat,
    output logic [15:0] mul_res
);

    logic [15:0]        prod_u_s;
    logic signed [15:0] prod_s_s;

    // Lane product with optional signed / saturating interpretation
    always_comb begin
        prod_u_s = {8'd0, a} * {8'd0, b};
        prod_s_s = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
        mul_res  = prod_u_s;
        case ({sign, sat})
            2'b00: mul_res = prod_u_s;
            2'b10: mul_res = prod_s_s;
            2'b01: begin
                if (prod_u_s > 16'd255) begin
                    mul_res = 16'h00FF;
                end else begin
                    mul_res = prod_u_s;
                end
            end
            2'b11: begin
                if (prod_s_s > 16'sd127) begin
                    mul_res = 16'h007F;
                end else if (prod_s_s < -16'sd128) begin
                    mul_res = 16'hFF80;
                end else begin
                    mul_res = prod_s_s;
                end
            end
            default: mul_res = prod_u_s;
        endcase
    end

endmodule

module lpmul_seq #(
    parameter int NLANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NLANES*8-1:0]   opA,
    input  logic [NLANES*8-1:0]   opB,
    input  logic                  sign,
    input  logic                  sat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NLANES*16-1:0]  out_res,
    output logic                  busy
);

    localparam int CW = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(NLANES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic [NLANES*8-1:0]    a_r;
    logic [NLANES*8-1:0]    b_r;
    logic                   sign_r;
    logic                   sat_r;
    logic [NLANES*16-1:0]   res_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   busy_r;
    logic [7:0]             lane_a_s;
    logic [7:0]             lane_b_s;
    logic [15:0]            mul_res_s;

    assign lane_a_s = a_r[8*cnt_r +: 8];
    assign lane_b_s = b_r[8*cnt_r +: 8];

    lpmul u_lpmul (
        .a       (lane_a_s),
        .b       (lane_b_s),
        .sign    (sign_r),
        .sat     (sat_r),
        .mul_res (mul_res_s)
    );

    // Sequencer: capture, step one lane per cycle, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            sign_r      <= 1'b0;
            sat_r       <= 1'b0;
            res_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= opA;
                        b_r        <= opB;
                        sign_r     <= sign;
                        sat_r      <= sat;
                        cnt_r      <= '0;
                        state_r    <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
                    res_r[16*cnt_r +: 16] <= mul_res_s;
                    if (cnt_r == LAST_LANE) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    // Accepting here is deliberately blocked; IDLE re-opens next cycle
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_res   = res_r;

endmodule
